// File: rtl/axis_s2mm_writer.sv
// AXI4-Stream to AXI4 memory-mapped write engine.
// Writes one stream transfer to memory from dst_addr using INCR bursts. Only one
// burst is in flight at a time. W data passes straight through from the stream.
//
// state  | meaning
// IDLE   | waiting for start
// AW     | burst address presented, waiting for m_awready
// W      | stream beats forwarded to the W channel until wlast
// B      | waiting for the write response of the current burst
// DONE   | one-cycle done pulse, then back to IDLE
module axis_s2mm_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     dst_addr,
  input  logic [LEN_WIDTH-1:0]      xfer_beats,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                err,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  input  logic                      s_tlast,
  input  logic                      s_tuser,
  input  logic [DATA_WIDTH-1:0]     s_tdata,
  input  logic [DATA_WIDTH/8-1:0]   s_tstrb,
  output logic [ADDR_WIDTH-1:0]     m_awaddr,
  output logic [7:0]                m_awlen,
  output logic [2:0]                m_awsize,
  output logic [1:0]                m_awburst,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [DATA_WIDTH-1:0]     m_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_wstrb,
  output logic                      m_wlast,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  input  logic [1:0]                m_bresp,
  input  logic                      m_bvalid,
  output logic                      m_bready
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int SIZE   = $clog2(STRB_W);
  localparam logic [31:0] MAX_B = MAX_BURST;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AW   = 3'd1;
  localparam logic [2:0] S_W    = 3'd2;
  localparam logic [2:0] S_B    = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]            state;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [7:0]            beat_cnt;
  logic [8:0]            blen;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [LEN_WIDTH-1:0]  rem_next;
  logic                  w_fire;
  logic                  final_beat;
  logic                  unused_bits;

  // Burst length (minus one) for a burst at address a with r beats left:
  // limited by remaining beats, MAX_BURST and the next 4 KB boundary.
  function automatic logic [7:0] awlen_of(input logic [ADDR_WIDTH-1:0] a,
                                          input logic [LEN_WIDTH-1:0] r);
    logic [12:0] to_bound;
    logic [31:0] lim;
    to_bound = 13'h1000 - {1'b0, a[11:0]};
    lim = 32'(to_bound >> SIZE);
    if (lim > MAX_B) lim = MAX_B;
    if (32'(r) < lim) lim = 32'(r);
    return 8'(lim - 32'd1);
  endfunction

  assign start_addr = {dst_addr[ADDR_WIDTH-1:SIZE], {SIZE{1'b0}}};
  assign blen       = {1'b0, m_awlen} + 9'd1;
  assign addr_next  = m_awaddr + (ADDR_WIDTH'(blen) << SIZE);
  assign rem_next   = remaining - LEN_WIDTH'(blen);

  assign m_awvalid  = (state == S_AW);
  assign m_awsize   = 3'(SIZE);
  assign m_awburst  = 2'b01;
  assign m_wvalid   = (state == S_W) && s_tvalid;
  assign s_tready   = (state == S_W) && m_wready;
  assign m_wdata    = s_tdata;
  assign m_wstrb    = s_tstrb;
  assign m_wlast    = (state == S_W) && (beat_cnt == m_awlen);
  assign m_bready   = (state == S_B);
  assign busy       = (state == S_AW) || (state == S_W) || (state == S_B);
  assign done       = (state == S_DONE);
  assign w_fire     = m_wvalid && m_wready;
  // The last beat of the whole transfer is the wlast beat of the burst that
  // consumes everything still remaining.
  assign final_beat = m_wlast && (remaining == LEN_WIDTH'(blen));
  assign unused_bits = s_tuser ^ (^dst_addr[SIZE-1:0]);

  // Transfer sequencing: burst setup, beat counting, response handling, error flags.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state     <= S_IDLE;
      m_awaddr  <= '0;
      m_awlen   <= '0;
      remaining <= '0;
      beat_cnt  <= '0;
      err       <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          if (start) begin
            err       <= '0;
            beat_cnt  <= '0;
            remaining <= xfer_beats;
            if (xfer_beats == '0) begin
              state <= S_DONE;
            end else begin
              state    <= S_AW;
              m_awaddr <= start_addr;
              m_awlen  <= awlen_of(start_addr, xfer_beats);
            end
          end
        end
        S_AW: begin
          if (m_awready) state <= S_W;
        end
        S_W: begin
          if (w_fire) begin
            if (s_tlast != final_beat) err[1] <= 1'b1;
            if (m_wlast) begin
              beat_cnt <= '0;
              state    <= S_B;
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
            end
          end
        end
        S_B: begin
          if (m_bvalid) begin
            if (m_bresp != 2'b00) err[0] <= 1'b1;
            remaining <= rem_next;
            m_awaddr  <= addr_next;
            if (rem_next == '0) begin
              state <= S_DONE;
            end else begin
              state   <= S_AW;
              m_awlen <= awlen_of(addr_next, rem_next);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_s2mm_writer.sv
// Bench for axis_s2mm_writer: random stream source and AXI slave with stalls,
// memory image and burst list compared against a reference built from the
// transfer rules (4 KB / MAX_BURST split, TLAST and BRESP error flags).
module tb_axis_s2mm_writer;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } aw_t;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dst_addr = '0;
  logic [15:0] xfer_beats = '0;
  logic        busy, done;
  logic [1:0]  err;
  logic        s_tvalid = 1'b0, s_tready, s_tlast = 1'b0, s_tuser = 1'b0;
  logic [31:0] s_tdata = '0;
  logic [3:0]  s_tstrb = '0;
  logic [31:0] m_awaddr;
  logic [7:0]  m_awlen;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst;
  logic        m_awvalid, m_awready = 1'b0;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wlast, m_wvalid, m_wready = 1'b0;
  logic [1:0]  m_bresp = 2'b00;
  logic        m_bvalid = 1'b0, m_bready;

  axis_s2mm_writer #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_BURST(16), .LEN_WIDTH(16)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .dst_addr(dst_addr),
    .xfer_beats(xfer_beats), .busy(busy), .done(done), .err(err),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast), .s_tuser(s_tuser),
    .s_tdata(s_tdata), .s_tstrb(s_tstrb),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_err = 0;

  // bench state
  logic        rst_n_req = 1'b0;
  logic        start_req = 1'b0;
  int          tv_pct = 100, wr_pct = 100, aw_pct = 100, bv_pct = 100;
  logic [35:0] src_q[$];
  int          src_idx, tlast_pos;
  logic [31:0] slverr_mask;
  logic [35:0] mem [logic [31:0]];
  aw_t         aw_obs[$];
  aw_t         aw_exp[$];
  aw_t         aw_hold;
  bit          aw_wait, s_taken, b_taken;
  int          w_burst, w_beat, wr_cnt, b_cnt, b_owed;
  int          cyc = 0, done_cnt, done_cyc, last_b_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: drive inputs just after the falling edge, then observe what the
  // next rising edge will see and update the bench's slave/memory model.
  task automatic cycle();
    logic [31:0] a;
    @(negedge ACLK);
    cyc++;
    ARESETN = rst_n_req;
    start = start_req;
    start_req = 1'b0;
    if (s_taken) begin s_tvalid = 1'b0; s_taken = 1'b0; end
    if (b_taken) begin m_bvalid = 1'b0; b_taken = 1'b0; end
    if (!s_tvalid && src_idx < src_q.size() && $urandom_range(99) < tv_pct) begin
      s_tvalid = 1'b1;
      {s_tstrb, s_tdata} = src_q[src_idx];
      s_tlast = (src_idx == tlast_pos);
      s_tuser = 1'($urandom);
    end
    m_awready = ($urandom_range(99) < aw_pct);
    m_wready  = ($urandom_range(99) < wr_pct);
    if (!m_bvalid && b_owed > 0 && $urandom_range(99) < bv_pct) begin
      m_bvalid = 1'b1;
      m_bresp  = slverr_mask[b_cnt % 32] ? 2'b10 : 2'b00;
    end
    #1;
    if (m_awvalid) begin
      if (aw_wait) begin
        chk("aw_addr_stable", m_awaddr, aw_hold.addr);
        chk("aw_len_stable", m_awlen, aw_hold.len);
      end
      if (m_awready) begin
        chk("aw_one_outstanding", b_cnt, aw_obs.size());
        chk("awsize", m_awsize, 2);
        chk("awburst", m_awburst, 1);
        aw_obs.push_back({m_awaddr, m_awlen});
        aw_wait = 1'b0;
      end else begin
        aw_wait = 1'b1;
        aw_hold = {m_awaddr, m_awlen};
      end
    end
    if (m_wvalid && m_wready) begin
      chk("w_after_aw", aw_obs.size() > w_burst, 1);
      if (aw_obs.size() > w_burst) begin
        a = aw_obs[w_burst].addr + 32'(w_beat) * 32'd4;
        mem[a] = {m_wstrb, m_wdata};
        wr_cnt++;
        chk("wlast", m_wlast, w_beat == int'(aw_obs[w_burst].len));
        if (m_wlast) begin w_burst++; w_beat = 0; b_owed++; end
        else w_beat++;
      end
    end
    if (s_tvalid && s_tready) begin src_idx++; s_taken = 1'b1; end
    if (m_bvalid && m_bready) begin
      b_owed--; b_cnt++; b_taken = 1'b1; last_b_cyc = cyc;
    end
    if (done) begin
      if (done_cnt == 0) done_cyc = cyc;
      done_cnt++;
    end
  endtask

  // Launch one transfer and check it against the reference. abort_at >= 0
  // returns early once that many beats are written (for the reset test);
  // poke fires a second start with junk config while busy.
  task automatic run_xfer(input logic [31:0] addr, input int n, input int tl_pos,
                          input logic [31:0] smask, input int abort_at, input bit poke);
    logic [31:0] base, a, ka;
    int rem, tb, bl;
    logic [1:0] exp_err;
    src_q.delete();
    for (int i = 0; i < n; i++) src_q.push_back({4'($urandom), 32'($urandom)});
    src_idx = 0; tlast_pos = tl_pos; slverr_mask = smask;
    mem.delete(); aw_obs.delete(); aw_exp.delete();
    w_burst = 0; w_beat = 0; wr_cnt = 0; b_cnt = 0; b_owed = 0; aw_wait = 1'b0;
    done_cnt = 0; done_cyc = -1; last_b_cyc = -1;

    base = {addr[31:2], 2'b00};
    a = base; rem = n;
    while (rem > 0) begin
      tb = (4096 - int'(a[11:0])) / 4;
      bl = rem;
      if (bl > 16) bl = 16;
      if (bl > tb) bl = tb;
      aw_exp.push_back({a, 8'(bl - 1)});
      a = a + 32'(bl * 4);
      rem -= bl;
    end
    exp_err = 2'b00;
    for (int k = 0; k < aw_exp.size(); k++) if (smask[k]) exp_err[0] = 1'b1;
    if (n > 0 && tl_pos != n - 1) exp_err[1] = 1'b1;

    dst_addr = addr; xfer_beats = 16'(n); start_req = 1'b1;
    cycle();
    for (int k = 0; k < 4000; k++) begin
      cycle();
      if (k == 0) begin
        chk("err_clear_on_start", err, 0);
        chk("busy_after_start", busy, n > 0);
        if (n > 0) chk("aw_latency", m_awvalid, 1);
        else chk("zero_done_latency", done, 1);
      end
      if (poke && k == 3) begin
        dst_addr = 32'hDEAD_0000; xfer_beats = 16'd3; start_req = 1'b1;
      end
      if (abort_at >= 0 && wr_cnt >= abort_at) return;
      if (done) break;
    end
    chk("done_seen", done_cnt > 0, 1);
    chk("busy_at_done", busy, 0);
    chk("err", err, exp_err);
    chk("burst_count", aw_obs.size(), aw_exp.size());
    for (int i = 0; i < aw_obs.size() && i < aw_exp.size(); i++) begin
      chk("burst_addr", aw_obs[i].addr, aw_exp[i].addr);
      chk("burst_len", aw_obs[i].len, aw_exp[i].len);
    end
    chk("beat_count", wr_cnt, n);
    for (int i = 0; i < n; i++) begin
      ka = base + 32'(i * 4);
      chk("mem", mem.exists(ka) ? 64'(mem[ka]) : 64'hx, 64'(src_q[i]));
    end
    if (n > 0) chk("b_to_done", done_cyc - last_b_cyc, 1);
    cycle();
    chk("done_pulse", done, 0);
    chk("err_sticky", err, exp_err);
  endtask

  initial begin
    rst_n_req = 1'b0;
    src_idx = 0; tlast_pos = -1; slverr_mask = '0; b_owed = 0; b_cnt = 0;
    w_burst = 0; w_beat = 0; wr_cnt = 0; done_cnt = 0;
    repeat (3) cycle();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_awvalid", m_awvalid, 0);
    chk("rst_awaddr", m_awaddr, 0);
    chk("rst_awlen", m_awlen, 0);
    rst_n_req = 1'b1;
    cycle();

    // directed, no stalls
    run_xfer(32'h0000_1000, 16, 15, 32'h0, -1, 1'b0);
    run_xfer(32'h0000_0000, 40, 39, 32'h0, -1, 1'b0);
    run_xfer(32'h0000_0FF8, 8, 7, 32'h0, -1, 1'b0);

    // random stalls everywhere, start poked while busy
    tv_pct = 60; wr_pct = 55; aw_pct = 40; bv_pct = 35;
    run_xfer(32'h0000_3F00 + 32'($urandom_range(63)) * 4, 100, 99, 32'h0, -1, 1'b1);
    run_xfer(32'($urandom) & 32'hFFFF_FFFC, 100, 99, 32'($urandom), -1, 1'b1);

    // TLAST early + SLVERR, then zero-length start clears err
    run_xfer(32'h0000_5000, 8, 3, 32'h1, -1, 1'b0);
    run_xfer(32'h0000_6000, 0, -1, 32'h0, -1, 1'b0);
    // missing TLAST, address wrap across 2^32 with SLVERR on second burst
    run_xfer(32'hFFFF_FFF0, 8, -1, 32'h2, -1, 1'b0);

    // reset mid-burst
    tv_pct = 100; wr_pct = 100; aw_pct = 100; bv_pct = 100;
    run_xfer(32'h0000_2000, 16, 15, 32'h0, 5, 1'b0);
    rst_n_req = 1'b0;
    cycle();
    cycle();
    chk("midrst_awvalid", m_awvalid, 0);
    chk("midrst_wvalid", m_wvalid, 0);
    chk("midrst_tready", s_tready, 0);
    chk("midrst_bready", m_bready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_awaddr", m_awaddr, 0);
    chk("midrst_awlen", m_awlen, 0);
    s_tvalid = 1'b0; m_bvalid = 1'b0; s_taken = 1'b0; b_taken = 1'b0;
    src_q.delete(); b_owed = 0;
    rst_n_req = 1'b1;
    cycle();
    run_xfer(32'h0000_2000, 16, 15, 32'h0, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
